// File: rtl/seg7_multi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_multi_driver
//  Description : Multi-digit 7-segment display driver. Captures a binary value
//                and shows it as hex or unsigned decimal (sequential
//                double-dabble), with optional leading-zero blanking, decimal
//                overflow dashes and per-digit blinking. Active-low segments.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_multi_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    mode,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] seg
);

    // A 32-bit binary value never needs more than 10 decimal digits, so the
    // BCD accumulator is sized for the worst case; the extra digits above
    // NUM_DIGITS exist only to detect overflow.
    localparam int c_BCD_DIGITS = 10;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_SEG_W      = 7 * NUM_DIGITS;
    localparam int c_HEX_W      = 4 * NUM_DIGITS;
    localparam int c_EXT_W      = (BIN_WIDTH > c_HEX_W) ? BIN_WIDTH : c_HEX_W;
    localparam int c_CNT_W      = $clog2(BIN_WIDTH);
    localparam int c_BLK_W      = $clog2(BLINK_DIV);

    localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] c_GLYPH_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    // Holds the captured value; in decimal mode it is shifted out MSB first,
    // in hex mode it stays untouched until WRITE reads it.
    logic [BIN_WIDTH-1:0] r_shift;
    logic                 r_mode;
    logic                 r_lz;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SEG_W-1:0]   r_dig;
    logic [c_SEG_W-1:0]   r_seg;
    logic [c_BLK_W-1:0]   r_bcnt;
    logic                 r_phase;

    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_BCD_W-1:0]   w_bcd_next;
    logic [c_EXT_W-1:0]   w_ext;
    logic                 w_ovf;
    logic                 w_seen;
    logic [3:0]           w_nib;
    logic [c_SEG_W-1:0]   w_new_dig;
    logic [c_SEG_W-1:0]   w_seg_next;

    // Hex nibble to active-low gfedcba glyph.
    function automatic logic [6:0] f_glyph(input logic [3:0] i_n);
        logic [6:0] v_g;
        case (i_n)
            4'h0:    v_g = 7'b1000000;
            4'h1:    v_g = 7'b1111001;
            4'h2:    v_g = 7'b0100100;
            4'h3:    v_g = 7'b0110000;
            4'h4:    v_g = 7'b0011001;
            4'h5:    v_g = 7'b0010010;
            4'h6:    v_g = 7'b0000010;
            4'h7:    v_g = 7'b1111000;
            4'h8:    v_g = 7'b0000000;
            4'h9:    v_g = 7'b0010000;
            4'hA:    v_g = 7'b0001000;
            4'hB:    v_g = 7'b0000011;
            4'hC:    v_g = 7'b1000110;
            4'hD:    v_g = 7'b0100001;
            4'hE:    v_g = 7'b0000110;
            default: v_g = 7'b0001110;
        endcase
        return v_g;
    endfunction

    // Double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[c_BCD_W-2:0], r_shift[BIN_WIDTH-1]};
    end

    // Build the glyph set for the next digit register contents.
    always_comb begin
        w_ext     = c_EXT_W'(r_shift);
        w_ovf     = 1'b0;
        w_seen    = 1'b0;
        w_nib     = 4'd0;
        w_new_dig = '1;
        for (int i = NUM_DIGITS; i < c_BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_ovf = r_mode;
            end
        end
        // Walk from the most significant digit so leading zeros are known.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nib = r_mode ? r_bcd[4*i +: 4] : w_ext[4*i +: 4];
            if (w_nib != 4'd0) begin
                w_seen = 1'b1;
            end
            if (w_ovf) begin
                w_new_dig[7*i +: 7] = c_GLYPH_DASH;
            end else if (r_lz && !w_seen && (i != 0)) begin
                w_new_dig[7*i +: 7] = c_GLYPH_BLANK;
            end else begin
                w_new_dig[7*i +: 7] = f_glyph(w_nib);
            end
        end
    end

    // Control FSM: capture, optional decimal conversion, digit register write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_mode  <= 1'b0;
            r_lz    <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_dig   <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= value;
                        r_mode  <= mode;
                        r_lz    <= lz_blank;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= mode ? S_CONV : S_WRITE;
                    end
                end
                S_CONV: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    if (r_cnt == c_CNT_W'(BIN_WIDTH - 1)) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_dig   <= w_new_dig;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running blink divider; the phase flips each time the counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == c_BLK_W'(BLINK_DIV - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    // Blank blinking digits during the active phase.
    always_comb begin
        w_seg_next = r_dig;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_phase && blink_mask[i]) begin
                w_seg_next[7*i +: 7] = c_GLYPH_BLANK;
            end
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '1;
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_multi_driver
//  Description : Self-checking bench for seg7_multi_driver (6 digits, 24-bit
//                value, blink divider of 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_multi_driver;

    localparam int c_ND  = 6;
    localparam int c_BW  = 24;
    localparam int c_BDV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [c_BW-1:0]   value;
    logic              mode;
    logic              lz_blank;
    logic [c_ND-1:0]   blink_mask;
    logic              busy;
    logic [7*c_ND-1:0] seg;

    int n_vec = 0;
    int n_bad = 0;
    int tb_cyc;
    logic [7*c_ND-1:0] cur_exp;

    typedef struct packed {
        logic [23:0] v;
        logic        m;
        logic        lz;
        logic [47:0] chars;
    } vec_t;

    vec_t tbl [10];

    seg7_multi_driver #(
        .NUM_DIGITS (c_ND),
        .BIN_WIDTH  (c_BW),
        .BLINK_DIV  (c_BDV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .mode       (mode),
        .lz_blank   (lz_blank),
        .blink_mask (blink_mask),
        .busy       (busy),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    // Edges seen since the last reset; drives the blink-phase expectation.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [6:0] g_char(input logic [7:0] c);
        case (c)
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            "A": return 7'b0001000;
            "b": return 7'b0000011;
            "C": return 7'b1000110;
            "d": return 7'b0100001;
            "E": return 7'b0000110;
            "F": return 7'b0001110;
            "-": return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Rightmost character of the string is digit 0.
    function automatic logic [7*c_ND-1:0] to_seg(input logic [47:0] chars);
        logic [7*c_ND-1:0] r;
        for (int i = 0; i < c_ND; i++) r[7*i +: 7] = g_char(chars[8*i +: 8]);
        return r;
    endfunction

    // Reference display text computed from the value with plain arithmetic.
    function automatic logic [47:0] model_chars(input logic [23:0] v, input bit m, input bit lz);
        logic [47:0]  s;
        logic [127:0] hc;
        int           d [c_ND];
        int           p;
        bit           seen;
        hc = "0123456789AbCdEF";
        if (m && int'(v) > 999999) return {6{8'h2D}};
        p = 1;
        for (int i = 0; i < c_ND; i++) begin
            d[i] = m ? (int'(v) / p) % 10 : (int'(v) >> (4 * i)) & 15;
            p    = p * 10;
        end
        seen = 0;
        for (int i = c_ND - 1; i >= 0; i--) begin
            if (d[i] != 0) seen = 1;
            if (lz && !seen && i != 0) s[8*i +: 8] = 8'h20;
            else                       s[8*i +: 8] = hc[8*(15 - d[i]) +: 8];
        end
        return s;
    endfunction

    task automatic chk_seg(input string name, input logic [7*c_ND-1:0] exp);
        n_vec++;
        if (seg !== exp) begin
            n_bad++;
            $display("FAIL %s: seg=%h expected %h", name, seg, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Load one value, check busy duration, the old display one edge before
    // the update and the new display on the update edge.
    task automatic apply(input string name, input logic [23:0] v, input bit m,
                         input bit lz, input logic [47:0] chars, input bit inject);
        int k;
        @(negedge clk);
        load = 1'b1; value = v; mode = m; lz_blank = lz;
        @(posedge clk); #1;
        load = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            k++;
            load  = inject && (k == 5);
            if (load) begin
                value = 24'h000999; mode = 1'b0; lz_blank = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        chk_int({name, " busy-cycles"}, k, m ? c_BW + 1 : 1);
        chk_seg({name, " pre-update"}, cur_exp);
        @(posedge clk); #1;
        cur_exp = to_seg(chars);
        chk_seg({name, " display"}, cur_exp);
    endtask

    initial begin
        logic [23:0] rv;
        bit          rm, rl;
        logic [7*c_ND-1:0] e;

        tbl[0] = '{24'h12AF0E, 1'b0, 1'b0, "12AF0E"};
        tbl[1] = '{24'd305,    1'b1, 1'b1, "   305"};
        tbl[2] = '{24'd1000000,1'b1, 1'b1, "------"};
        tbl[3] = '{24'd0,      1'b1, 1'b1, "     0"};
        tbl[4] = '{24'd999999, 1'b1, 1'b0, "999999"};
        tbl[5] = '{24'h00000B, 1'b0, 1'b1, "     b"};
        tbl[6] = '{24'd305,    1'b1, 1'b0, "000305"};
        tbl[7] = '{24'h000000, 1'b0, 1'b0, "000000"};
        tbl[8] = '{24'h00C0D0, 1'b0, 1'b1, "  C0d0"};
        tbl[9] = '{24'd42,     1'b1, 1'b0, "000042"};

        rst = 1'b1; load = 1'b0; value = '0; mode = 1'b0; lz_blank = 1'b0; blink_mask = '0;
        cur_exp = '1;
        #22;
        chk_seg("reset seg", '1);
        chk_int("reset busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++)
            apply($sformatf("tbl%0d", i), tbl[i].v, tbl[i].m, tbl[i].lz, tbl[i].chars, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rm = $urandom_range(0, 1);
            rl = $urandom_range(0, 1);
            if (rm && $urandom_range(0, 3) != 0) rv = 24'($urandom_range(0, 999999));
            else                                 rv = 24'($urandom);
            apply($sformatf("rand%0d", i), rv, rm, rl, model_chars(rv, rm, rl), 1'b0);
        end

        // Second load during conversion must be ignored.
        apply("inject", 24'd305, 1'b1, 1'b1, "   305", 1'b1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        load = 1'b1; value = 24'd123456; mode = 1'b1; lz_blank = 1'b0;
        @(posedge clk); #1; load = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_seg("abort seg", '1);
        chk_int("abort busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;
        cur_exp = '1;
        apply("post-reset", 24'h000007, 1'b0, 1'b0, "000007", 1'b0);

        // Blink digit 0 only; phase flips every c_BDV edges.
        @(negedge clk); blink_mask = 6'b000001;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            e = cur_exp;
            if (tb_cyc >= 1 && (((tb_cyc - 1) / c_BDV) % 2) == 1) e[6:0] = 7'b1111111;
            chk_seg($sformatf("blink%0d", i), e);
        end
        @(negedge clk); blink_mask = '0;
        @(posedge clk); #1;
        chk_seg("blink off", cur_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_multi_driver.md
SEG7_MULTI_DRIVER -- requirements
Module: seg7_multi_driver

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 6, number of 7-segment digits (legal 1..8).
REQ-002 SHALL provide parameter BIN_WIDTH, default 20, width of value input (legal 4..32).
REQ-003 SHALL provide parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (legal >=2).
REQ-004 Ports, in order:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to capture value/mode/lz_blank.
- value  input  BIN_WIDTH  number to display.
- mode  input  1  0 = hex, 1 = unsigned decimal.
- lz_blank  input  1  1 = blank leading zeros.
- blink_mask  input  NUM_DIGITS  bit i = 1 makes digit i blink.
- busy  output  1  conversion in progress.
- seg  output  7*NUM_DIGITS  active-low segments; digit i at [7i+6:7i], bit order g,f,e,d,c,b,a.

Function
REQ-005 FSM states SHALL be IDLE, CONV, WRITE.
REQ-006 In IDLE, load=1 SHALL capture value, mode and lz_blank on that edge and enter CONV (mode=1) or WRITE (mode=0).
REQ-007 load SHALL be ignored in CONV and WRITE; no queuing.
REQ-008 CONV SHALL perform sequential double-dabble, one bit per cycle MSB first, exactly BIN_WIDTH cycles, then enter WRITE.
REQ-009 WRITE SHALL update the internal digit register in one cycle and return to IDLE.
REQ-010 busy SHALL be 1 exactly while state is CONV or WRITE.
REQ-011 Latency: seg SHALL reflect new data on the 2nd edge after the load edge (hex) and the (BIN_WIDTH+2)th edge (decimal).
REQ-012 Hex mode: digit i SHALL show value[4i+3:4i], with value zero-extended when BIN_WIDTH < 4*NUM_DIGITS and upper bits ignored when larger.
REQ-013 Glyphs (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111, dash=0111111.
REQ-014 Decimal mode: digit i SHALL show BCD digit i of value.
REQ-015 Decimal overflow: if value > 10^NUM_DIGITS - 1, all digits SHALL show dash and lz_blank SHALL be ignored.
REQ-016 lz_blank=1: every digit above the most significant non-zero digit SHALL be blank; digit 0 SHALL always be shown (value 0 displays "0").
REQ-017 A free-running counter SHALL count 0..BLINK_DIV-1, wrap to 0 and toggle blink phase on wrap.
REQ-018 While blink phase = 1, each digit with blink_mask bit set SHALL show blank; otherwise it shows the digit register.
REQ-019 seg SHALL be registered; a blink_mask or phase change SHALL appear on seg one edge later.
REQ-020 Digit register SHALL hold its contents indefinitely between WRITEs.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, seg all ones (every digit blank), digit register blank, blink counter 0, blink phase 0.
REQ-022 rst asserted during CONV or WRITE SHALL abort the conversion; the pending value is never displayed.
REQ-023 After rst deassertion, the first load in IDLE SHALL be accepted normally.

Verification
REQ-024 Hex, NUM_DIGITS=6, BIN_WIDTH=24: load value=0x12AF0E, lz_blank=0 -> 2 edges later seg digits 5..0 = 1,2,A,F,0,E; busy high 1 cycle.
REQ-025 Decimal, BIN_WIDTH=20: load value=305, lz_blank=1 -> busy high 21 cycles; seg shows blank,blank,blank,3,0,5 on edge 22.
REQ-026 Decimal value=1000000 (6 digits) -> all six digits dash; value=0, lz_blank=1 -> digits 5..1 blank, digit 0 = 1000000.
REQ-027 Second load pulsed during CONV -> ignored; display shows only first value; busy profile unchanged.
REQ-028 BLINK_DIV=4, blink_mask=000001 -> digit 0 alternates glyph/blank every 4 cycles; other digits steady.
REQ-029 rst pulsed mid-CONV -> seg all ones, busy=0 immediately; following load of 0x7 (hex) displays 7 on digit 0.
